// File: rtl/om_write_ctrl_if.sv
// Beat-in / OM-write bus of the output-memory write controller.
//   in_valid, in_data : result beat from the convolution pipeline
//   in_ready          : controller can take a beat this cycle
//   om_we, om_addr,
//   om_wdata          : registered output-memory write port
// master = upstream/OM side of the bus, slave = the write controller.
interface om_write_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              om_we;
  logic [ADDR_W-1:0] om_addr;
  logic [DATA_W-1:0] om_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, om_we, om_addr, om_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, om_we, om_addr, om_wdata
  );
endinterface

// File: rtl/om_write_ctrl.sv
// Output-memory write controller. Fills OM with DEPTH sequential beats,
// flags the full frame to the set-enable clear stage, and re-arms once the
// clear stage has cleared the write pointer and the reader has released OM.
// Ports:
//   SETEN_CLR_Clk : clock, rising edge
//   rst_n         : asynchronous active-low reset
//   bus           : beat input handshake and registered OM write port
//   flag_om_full  : OM holds a complete frame (registered)
//   wptclr_n      : write-pointer clear from the clear stage, active-low
//   om_release    : one-cycle pulse, reader has consumed the frame
//   frame_done    : one-cycle pulse when the last beat of a frame is taken
//   frame_cnt     : completed frames, wraps
//
// state | meaning
// FILL  | accepting beats, writing OM sequentially
// FULL  | frame stored, waiting for the clear stage to pull wptclr_n low
// DRAIN | pointer cleared, waiting for the reader to release OM
// REARM | OM released, waiting for wptclr_n to return high
module om_write_ctrl #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10,
  parameter int FCNT_W = 16
) (
  input  logic              SETEN_CLR_Clk,
  input  logic              rst_n,
  om_write_ctrl_if.slave    bus,
  output logic              flag_om_full,
  input  logic              wptclr_n,
  input  logic              om_release,
  output logic              frame_done,
  output logic [FCNT_W-1:0] frame_cnt
);

  typedef enum logic [1:0] {FILL, FULL, DRAIN, REARM} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] wptr, wptr_nxt;
  logic              rel_pend, rel_pend_nxt;
  logic              done_nxt;
  logic [FCNT_W-1:0] cnt_nxt;
  logic              flag_nxt;
  logic              in_ready;
  logic              accept;
  logic              om_we_q;
  logic [ADDR_W-1:0] om_addr_q;
  logic [DATA_W-1:0] om_wdata_q;

  assign in_ready     = (state == FILL) & wptclr_n;
  assign accept       = bus.in_valid & in_ready;
  assign bus.in_ready = in_ready;
  assign bus.om_we    = om_we_q;
  assign bus.om_addr  = om_addr_q;
  assign bus.om_wdata = om_wdata_q;

  always_comb begin
    state_nxt    = state;
    wptr_nxt     = wptr;
    rel_pend_nxt = rel_pend;
    done_nxt     = 1'b0;
    cnt_nxt      = frame_cnt;
    case (state)
      FILL: begin
        if (!wptclr_n) begin
          // clear stage aborts the partial frame
          wptr_nxt = '0;
        end else if (accept) begin
          if (wptr == LAST_ADDR) begin
            // pointer parks on the last word until the clear stage resets it
            state_nxt = FULL;
            done_nxt  = 1'b1;
            cnt_nxt   = frame_cnt + FCNT_W'(1);
          end else begin
            wptr_nxt = wptr + ADDR_W'(1);
          end
        end
      end
      FULL: begin
        // an early release is remembered so DRAIN can exit immediately
        if (om_release) rel_pend_nxt = 1'b1;
        if (!wptclr_n) begin
          wptr_nxt  = '0;
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (om_release || rel_pend) begin
          rel_pend_nxt = 1'b0;
          state_nxt    = REARM;
        end
      end
      REARM: begin
        if (wptclr_n) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
    flag_nxt = (state_nxt == FULL) || (state_nxt == DRAIN);
  end

  always_ff @(posedge SETEN_CLR_Clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= FILL;
      wptr         <= '0;
      rel_pend     <= 1'b0;
      flag_om_full <= 1'b0;
      frame_done   <= 1'b0;
      frame_cnt    <= '0;
      om_we_q      <= 1'b0;
      om_addr_q    <= '0;
      om_wdata_q   <= '0;
    end else begin
      state        <= state_nxt;
      wptr         <= wptr_nxt;
      rel_pend     <= rel_pend_nxt;
      flag_om_full <= flag_nxt;
      frame_done   <= done_nxt;
      frame_cnt    <= cnt_nxt;
      om_we_q      <= accept;
      if (accept) begin
        om_addr_q  <= wptr;
        om_wdata_q <= bus.in_data;
      end
    end
  end

endmodule

// File: tb/tb_om_write_ctrl.sv
module tb_om_write_ctrl;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;
  localparam int FCNT_W = 2;

  logic              clk;
  logic              rst_n;
  logic              flag_om_full;
  logic              wptclr_n;
  logic              om_release;
  logic              frame_done;
  logic [FCNT_W-1:0] frame_cnt;
  logic              force_clr;

  int n_cmp = 0;
  int n_err = 0;

  om_write_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  om_write_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .FCNT_W(FCNT_W)) dut (
    .SETEN_CLR_Clk(clk),
    .rst_n        (rst_n),
    .bus          (bus.slave),
    .flag_om_full (flag_om_full),
    .wptclr_n     (wptclr_n),
    .om_release   (om_release),
    .frame_done   (frame_done),
    .frame_cnt    (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // clear stage model: samples the flag on the falling edge
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) wptclr_n <= 1'b1;
    else        wptclr_n <= ~(flag_om_full | force_clr);
  end

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       rel;
    logic       rdy;
    logic       we;
    logic [1:0] addr;
    logic [7:0] wd;
    logic       flag;
    logic       done;
    logic [1:0] cnt;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // drive inputs 1 after the rising edge, leave at +3 (before the falling edge)
  task automatic cyc(input logic v, input logic [7:0] d, input logic r);
    @(posedge clk);
    #1;
    bus.in_valid = v;
    bus.in_data  = d;
    om_release   = r;
    #2;
  endtask

  task automatic chk_wr(input string name, input logic we, input logic [1:0] addr, input logic [7:0] wd);
    chk({name, ".we"}, 32'(bus.om_we), 32'(we));
    if (we) begin
      chk({name, ".addr"}, 32'(bus.om_addr), 32'(addr));
      chk({name, ".wdata"}, 32'(bus.om_wdata), 32'(wd));
    end
  endtask

  // DRAIN -> REARM -> FILL, bounded
  task automatic finish_frame(input string name);
    int k;
    cyc(1'b0, 8'h00, 1'b1);
    k = 0;
    while (!(bus.in_ready === 1'b1) && k < 10) begin
      cyc(1'b0, 8'h00, 1'b0);
      k++;
    end
    chk({name, ".rearm_in_time"}, 32'(bus.in_ready), 32'd1);
  endtask

  task automatic stream4(input logic [7:0] base);
    for (int i = 0; i < 4; i++) cyc(1'b1, base + 8'(i), 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] dd [4];
    // v, d, rel | rdy, we, addr, wd, flag, done, cnt
    vecs[0] = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0};
    vecs[1] = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 2'd0, 8'h11, 1'b0, 1'b0, 2'd0};
    vecs[2] = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 2'd1, 8'h22, 1'b0, 1'b0, 2'd0};
    vecs[3] = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 2'd2, 8'h33, 1'b0, 1'b0, 2'd0};
    vecs[4] = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 2'd3, 8'h44, 1'b1, 1'b1, 2'd1};
    vecs[5] = '{1'b1, 8'h66, 1'b0, 1'b0, 1'b0, 2'd3, 8'h44, 1'b1, 1'b0, 2'd1};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'd3, 8'h44, 1'b1, 1'b0, 2'd1};
    vecs[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd3, 8'h44, 1'b0, 1'b0, 2'd1};
    vecs[8] = '{1'b1, 8'hA1, 1'b0, 1'b1, 1'b0, 2'd3, 8'h44, 1'b0, 1'b0, 2'd1};
    vecs[9] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 2'd0, 8'hA1, 1'b0, 1'b0, 2'd1};

    rst_n        = 1'b0;
    force_clr    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    om_release   = 1'b0;
    #3;
    chk("reset.we", 32'(bus.om_we), 32'd0);
    chk("reset.flag", 32'(flag_om_full), 32'd0);
    chk("reset.cnt", 32'(frame_cnt), 32'd0);
    #9 rst_n = 1'b1;

    // first frame, drain and start of the second frame
    for (int i = 0; i < 10; i++) begin
      cyc(vecs[i].v, vecs[i].d, vecs[i].rel);
      chk($sformatf("vec%0d.ready", i), 32'(bus.in_ready), 32'(vecs[i].rdy));
      chk($sformatf("vec%0d.we", i), 32'(bus.om_we), 32'(vecs[i].we));
      chk($sformatf("vec%0d.addr", i), 32'(bus.om_addr), 32'(vecs[i].addr));
      chk($sformatf("vec%0d.wdata", i), 32'(bus.om_wdata), 32'(vecs[i].wd));
      chk($sformatf("vec%0d.flag", i), 32'(flag_om_full), 32'(vecs[i].flag));
      chk($sformatf("vec%0d.done", i), 32'(frame_done), 32'(vecs[i].done));
      chk($sformatf("vec%0d.cnt", i), 32'(frame_cnt), 32'(vecs[i].cnt));
    end

    // release arrives while still FULL: remembered, DRAIN exits at once
    cyc(1'b1, 8'hB2, 1'b0);
    cyc(1'b1, 8'hB3, 1'b0);
    cyc(1'b1, 8'hB4, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    chk("early_rel.full_flag", 32'(flag_om_full), 32'd1);
    chk("early_rel.full_done", 32'(frame_done), 32'd1);
    chk("early_rel.full_cnt", 32'(frame_cnt), 32'd2);
    chk("early_rel.full_ready", 32'(bus.in_ready), 32'd0);
    chk_wr("early_rel.last", 1'b1, 2'd3, 8'hB4);
    cyc(1'b0, 8'h00, 1'b0);
    chk("early_rel.drain_flag", 32'(flag_om_full), 32'd1);
    cyc(1'b0, 8'h00, 1'b0);
    chk("early_rel.rearm_flag", 32'(flag_om_full), 32'd0);
    chk("early_rel.rearm_ready", 32'(bus.in_ready), 32'd0);
    cyc(1'b1, 8'hC1, 1'b0);
    chk("early_rel.fill_ready", 32'(bus.in_ready), 32'd1);
    cyc(1'b1, 8'hC2, 1'b0);
    chk_wr("early_rel.first", 1'b1, 2'd0, 8'hC1);

    // asynchronous reset mid-frame
    cyc(1'b0, 8'h00, 1'b0);
    chk_wr("midrst.pre", 1'b1, 2'd1, 8'hC2);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst.we", 32'(bus.om_we), 32'd0);
    chk("midrst.addr", 32'(bus.om_addr), 32'd0);
    chk("midrst.wdata", 32'(bus.om_wdata), 32'd0);
    chk("midrst.flag", 32'(flag_om_full), 32'd0);
    chk("midrst.done", 32'(frame_done), 32'd0);
    chk("midrst.cnt", 32'(frame_cnt), 32'd0);
    #2 rst_n = 1'b1;
    dd[0] = 8'hD1; dd[1] = 8'hD2; dd[2] = 8'hD3; dd[3] = 8'hD4;
    cyc(1'b1, dd[0], 1'b0);
    chk("midrst.idle_we", 32'(bus.om_we), 32'd0);
    for (int i = 1; i < 4; i++) begin
      cyc(1'b1, dd[i], 1'b0);
      chk_wr($sformatf("midrst.beat%0d", i - 1), 1'b1, 2'(i - 1), dd[i - 1]);
      chk($sformatf("midrst.done%0d", i - 1), 32'(frame_done), 32'd0);
    end
    cyc(1'b0, 8'h00, 1'b0);
    chk_wr("midrst.beat3", 1'b1, 2'd3, dd[3]);
    chk("midrst.frame_done", 32'(frame_done), 32'd1);
    chk("midrst.cnt_after", 32'(frame_cnt), 32'd1);
    finish_frame("midrst");

    // wptclr_n forced low for one cycle in FILL after three beats
    cyc(1'b1, 8'hE1, 1'b0);
    cyc(1'b1, 8'hE2, 1'b0);
    cyc(1'b1, 8'hE3, 1'b0);
    cyc(1'b1, 8'hEE, 1'b0);
    force_clr = 1'b1;
    #4;
    chk("fclr.ready_low", 32'(bus.in_ready), 32'd0);
    cyc(1'b1, 8'hF1, 1'b0);
    force_clr = 1'b0;
    chk("fclr.ready_still_low", 32'(bus.in_ready), 32'd0);
    chk("fclr.no_accept", 32'(bus.om_we), 32'd0);
    cyc(1'b1, 8'hF2, 1'b0);
    chk_wr("fclr.beat0", 1'b1, 2'd0, 8'hF1);
    cyc(1'b1, 8'hF3, 1'b0);
    chk_wr("fclr.beat1", 1'b1, 2'd1, 8'hF2);
    cyc(1'b1, 8'hF4, 1'b0);
    chk_wr("fclr.beat2", 1'b1, 2'd2, 8'hF3);
    chk("fclr.no_early_done", 32'(frame_done), 32'd0);
    cyc(1'b0, 8'h00, 1'b0);
    chk_wr("fclr.beat3", 1'b1, 2'd3, 8'hF4);
    chk("fclr.done", 32'(frame_done), 32'd1);
    chk("fclr.cnt", 32'(frame_cnt), 32'd2);
    cyc(1'b0, 8'h00, 1'b0);
    chk("fclr.done_once", 32'(frame_done), 32'd0);
    chk("fclr.no_extra_we", 32'(bus.om_we), 32'd0);
    finish_frame("fclr");

    // frame counter wrap with a 2-bit counter
    stream4(8'h30);
    chk("wrap.cnt3", 32'(frame_cnt), 32'd3);
    finish_frame("wrap1");
    stream4(8'h40);
    chk("wrap.cnt0", 32'(frame_cnt), 32'd0);
    chk("wrap.flag", 32'(flag_om_full), 32'd1);
    finish_frame("wrap2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
